// File: rtl/mem_arbiter_pkg.sv
// Shared memory-subsystem definitions: default line geometry and the
// arbiter state encodings.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 28;
  localparam int unsigned DATA_W_DEF = 128;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE    = 2'd0;
  localparam arb_state_t ST_GNT_I   = 2'd1;
  localparam arb_state_t ST_GNT_D   = 2'd2;
  localparam arb_state_t ST_RELEASE = 2'd3;

endpackage

// File: rtl/mem_arbiter_arb_rdata_hold.sv
// Per-client return path: one-cycle ready pulse on load, and a read-data
// register that only changes when a read completes.
module arb_rdata_hold
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              capture_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              ready_o
);

  logic [DATA_W-1:0] rdata_q;
  logic              ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= load_i;
      // Writes complete with a pulse but leave the held line untouched.
      if (load_i && capture_i) begin
        rdata_q <= rdata_i;
      end
    end
  end

  assign rdata_o = rdata_q;
  assign ready_o = ready_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-client (I-cache / D-cache) arbiter for the single line-wide memory
// port, round-robin on ties, with a dead RELEASE cycle after each completion.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              ic_mem_read,
  input  logic [ADDR_W-1:0] ic_mem_addr,
  output logic [DATA_W-1:0] ic_mem_rdata,
  output logic              ic_mem_ready,
  input  logic              dc_mem_read,
  input  logic              dc_mem_write,
  input  logic [ADDR_W-1:0] dc_mem_addr,
  input  logic [DATA_W-1:0] dc_mem_wdata,
  output logic [DATA_W-1:0] dc_mem_rdata,
  output logic              dc_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_t        state_q, state_d;
  logic              d_pri_q, d_pri_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic dc_req;
  logic pick_d;
  logic ic_load;
  logic dc_load;

  assign dc_req  = dc_mem_read | dc_mem_write;
  assign pick_d  = dc_req & (~ic_mem_read | d_pri_q);
  assign ic_load = (state_q == ST_GNT_I) & mem_ready;
  assign dc_load = (state_q == ST_GNT_D) & mem_ready;

  always_comb begin
    state_d     = state_q;
    d_pri_d     = d_pri_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_d) begin
          // A D-side read+write collision is treated as a write-back only.
          state_d     = ST_GNT_D;
          d_pri_d     = 1'b0;
          mem_write_d = dc_mem_write;
          mem_read_d  = dc_mem_read & ~dc_mem_write;
          mem_addr_d  = dc_mem_addr;
          mem_wdata_d = dc_mem_wdata;
        end else if (ic_mem_read) begin
          state_d     = ST_GNT_I;
          d_pri_d     = 1'b1;
          mem_write_d = 1'b0;
          mem_read_d  = 1'b1;
          mem_addr_d  = ic_mem_addr;
          mem_wdata_d = '0;
        end
      end
      ST_GNT_I, ST_GNT_D: begin
        if (mem_ready) begin
          state_d     = ST_RELEASE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q     <= ST_IDLE;
      d_pri_q     <= 1'b1;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      d_pri_q     <= d_pri_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  arb_rdata_hold #(.DATA_W(DATA_W)) u_ic_hold (
    .clk       (clk),
    .rst       (proc_reset),
    .load_i    (ic_load),
    .capture_i (1'b1),
    .rdata_i   (mem_rdata),
    .rdata_o   (ic_mem_rdata),
    .ready_o   (ic_mem_ready)
  );

  // mem_read_q is still the granted command during the completion cycle.
  arb_rdata_hold #(.DATA_W(DATA_W)) u_dc_hold (
    .clk       (clk),
    .rst       (proc_reset),
    .load_i    (dc_load),
    .capture_i (mem_read_q),
    .rdata_i   (mem_rdata),
    .rdata_o   (dc_mem_rdata),
    .ready_o   (dc_mem_ready)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single reads, ties, round-robin, write-back,
// held mem_ready, illegal D read+write and reset mid-transaction.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         proc_reset;
  logic         ic_mem_read;
  logic [27:0]  ic_mem_addr;
  logic [127:0] ic_mem_rdata;
  logic         ic_mem_ready;
  logic         dc_mem_read;
  logic         dc_mem_write;
  logic [27:0]  dc_mem_addr;
  logic [127:0] dc_mem_wdata;
  logic [127:0] dc_mem_rdata;
  logic         dc_mem_ready;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  localparam logic [127:0] A5 = {16{8'hA5}};

  mem_arbiter #(.ADDR_W(28), .DATA_W(128)) dut (
    .clk          (clk),
    .proc_reset   (proc_reset),
    .ic_mem_read  (ic_mem_read),
    .ic_mem_addr  (ic_mem_addr),
    .ic_mem_rdata (ic_mem_rdata),
    .ic_mem_ready (ic_mem_ready),
    .dc_mem_read  (dc_mem_read),
    .dc_mem_write (dc_mem_write),
    .dc_mem_addr  (dc_mem_addr),
    .dc_mem_wdata (dc_mem_wdata),
    .dc_mem_rdata (dc_mem_rdata),
    .dc_mem_ready (dc_mem_ready),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_mem_read"},  {127'd0, mem_read},      128'd0);
    chk({pfx, "_mem_write"}, {127'd0, mem_write},     128'd0);
    chk({pfx, "_mem_addr"},  {100'd0, mem_addr},      128'd0);
    chk({pfx, "_mem_wdata"}, mem_wdata,               128'd0);
    chk({pfx, "_ic_ready"},  {127'd0, ic_mem_ready},  128'd0);
    chk({pfx, "_dc_ready"},  {127'd0, dc_mem_ready},  128'd0);
    chk({pfx, "_ic_rdata"},  ic_mem_rdata,            128'd0);
    chk({pfx, "_dc_rdata"},  dc_mem_rdata,            128'd0);
  endtask

  // Waits (bounded) for the next grant, checks its address, then completes it.
  task automatic serve(input logic [27:0] exp_addr, input logic exp_d, input logic [127:0] data);
    int unsigned n;
    n = 0;
    while (!mem_read && n < 10) begin
      tick();
      n++;
    end
    chk("rr_grant_seen", {127'd0, mem_read}, 128'd1);
    chk("rr_addr", {100'd0, mem_addr}, {100'd0, exp_addr});
    mem_ready = 1'b1;
    mem_rdata = data;
    tick();
    mem_ready = 1'b0;
    chk("rr_dc_ready", {127'd0, dc_mem_ready}, {127'd0, exp_d});
    chk("rr_ic_ready", {127'd0, ic_mem_ready}, {127'd0, ~exp_d});
    if (exp_d) chk("rr_dc_rdata", dc_mem_rdata, data);
    else       chk("rr_ic_rdata", ic_mem_rdata, data);
  endtask

  initial begin
    proc_reset   = 1'b1;
    ic_mem_read  = 1'b0;
    ic_mem_addr  = '0;
    dc_mem_read  = 1'b0;
    dc_mem_write = 1'b0;
    dc_mem_addr  = '0;
    dc_mem_wdata = '0;
    mem_rdata    = '0;
    mem_ready    = 1'b0;
    tick();
    tick();
    chk_all_zero("rst");
    proc_reset = 1'b0;
    tick();

    // I-only read, memory answers 4 cycles after mem_read.
    ic_mem_read = 1'b1;
    ic_mem_addr = 28'h0000010;
    chk("i1_no_early_read", {127'd0, mem_read}, 128'd0);
    tick();
    chk("i1_read_rise", {127'd0, mem_read}, 128'd1);
    chk("i1_addr", {100'd0, mem_addr}, 128'h10);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("i1_wait_ready", {127'd0, ic_mem_ready}, 128'd0);
      chk("i1_wait_read", {127'd0, mem_read}, 128'd1);
    end
    mem_ready = 1'b1;
    mem_rdata = A5;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    chk("i1_ready", {127'd0, ic_mem_ready}, 128'd1);
    chk("i1_rdata", ic_mem_rdata, A5);
    chk("i1_read_drop", {127'd0, mem_read}, 128'd0);
    chk("i1_dc_ready", {127'd0, dc_mem_ready}, 128'd0);
    ic_mem_read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("i1_ready_once", {127'd0, ic_mem_ready}, 128'd0);
      chk("i1_rdata_hold", ic_mem_rdata, A5);
      chk("i1_dc_quiet", {127'd0, dc_mem_ready}, 128'd0);
    end

    // Simultaneous requests straight out of reset: D first, then I.
    proc_reset = 1'b1;
    tick();
    proc_reset = 1'b0;
    ic_mem_read = 1'b1;
    ic_mem_addr = 28'h10;
    dc_mem_read = 1'b1;
    dc_mem_addr = 28'h20;
    tick();
    chk("tie_read", {127'd0, mem_read}, 128'd1);
    chk("tie_addr_d", {100'd0, mem_addr}, 128'h20);
    mem_ready = 1'b1;
    mem_rdata = 128'hD0;
    tick();
    mem_ready = 1'b0;
    dc_mem_read = 1'b0;
    chk("tie_dc_ready", {127'd0, dc_mem_ready}, 128'd1);
    chk("tie_dc_rdata", dc_mem_rdata, 128'hD0);
    chk("tie_ic_ready0", {127'd0, ic_mem_ready}, 128'd0);
    chk("tie_r1_read", {127'd0, mem_read}, 128'd0);
    tick();
    chk("tie_r2_read", {127'd0, mem_read}, 128'd0);
    tick();
    chk("tie_r3_read", {127'd0, mem_read}, 128'd1);
    chk("tie_addr_i", {100'd0, mem_addr}, 128'h10);
    mem_ready = 1'b1;
    mem_rdata = 128'hE1;
    tick();
    mem_ready = 1'b0;
    chk("tie_ic_ready", {127'd0, ic_mem_ready}, 128'd1);
    chk("tie_ic_rdata", ic_mem_rdata, 128'hE1);
    chk("tie_dc_rdata_hold", dc_mem_rdata, 128'hD0);

    // Round-robin with both clients requesting continuously.
    ic_mem_addr = 28'h40;
    dc_mem_addr = 28'h50;
    dc_mem_read = 1'b1;
    serve(28'h50, 1'b1, 128'h11);
    serve(28'h40, 1'b0, 128'h22);
    serve(28'h50, 1'b1, 128'h33);
    serve(28'h40, 1'b0, 128'h44);
    ic_mem_read = 1'b0;
    dc_mem_read = 1'b0;
    tick();
    tick();

    // D write-back; command, address and data latched at grant.
    dc_mem_write = 1'b1;
    dc_mem_addr  = 28'h30;
    dc_mem_wdata = 128'h1234;
    tick();
    chk("wb_write", {127'd0, mem_write}, 128'd1);
    chk("wb_read0", {127'd0, mem_read}, 128'd0);
    chk("wb_addr", {100'd0, mem_addr}, 128'h30);
    chk("wb_wdata", mem_wdata, 128'h1234);
    dc_mem_addr  = 28'h99;
    dc_mem_wdata = 128'hBAD;
    tick();
    tick();
    chk("wb_addr_stable", {100'd0, mem_addr}, 128'h30);
    chk("wb_wdata_stable", mem_wdata, 128'h1234);
    chk("wb_write_stable", {127'd0, mem_write}, 128'd1);
    mem_ready = 1'b1;
    mem_rdata = 128'hFFFF;
    tick();
    mem_ready = 1'b0;
    dc_mem_write = 1'b0;
    chk("wb_dc_ready", {127'd0, dc_mem_ready}, 128'd1);
    chk("wb_dc_rdata_kept", dc_mem_rdata, 128'h33);
    chk("wb_write_drop", {127'd0, mem_write}, 128'd0);
    tick();
    tick();

    // mem_ready held 3 cycles; I wins the tie (D was granted last).
    ic_mem_read = 1'b1;
    ic_mem_addr = 28'h60;
    dc_mem_read = 1'b1;
    dc_mem_addr = 28'h70;
    tick();
    chk("hold_grant_i", {100'd0, mem_addr}, 128'h60);
    chk("hold_read", {127'd0, mem_read}, 128'd1);
    mem_ready = 1'b1;
    mem_rdata = 128'h55;
    tick();
    ic_mem_read = 1'b0;
    chk("hold_ic_ready", {127'd0, ic_mem_ready}, 128'd1);
    chk("hold_read_drop", {127'd0, mem_read}, 128'd0);
    tick();
    chk("hold_ic_ready_once", {127'd0, ic_mem_ready}, 128'd0);
    chk("hold_release_idle", {127'd0, mem_read}, 128'd0);
    tick();
    mem_ready = 1'b0;
    chk("hold_dc_grant", {127'd0, mem_read}, 128'd1);
    chk("hold_dc_addr", {100'd0, mem_addr}, 128'h70);
    chk("hold_no_ic_ready", {127'd0, ic_mem_ready}, 128'd0);
    tick();
    chk("hold_dc_not_done", {127'd0, dc_mem_ready}, 128'd0);
    chk("hold_dc_still_read", {127'd0, mem_read}, 128'd1);
    mem_ready = 1'b1;
    mem_rdata = 128'h77;
    tick();
    mem_ready = 1'b0;
    dc_mem_read = 1'b0;
    chk("hold_dc_ready", {127'd0, dc_mem_ready}, 128'd1);
    chk("hold_dc_rdata", dc_mem_rdata, 128'h77);
    chk("hold_ic_rdata", ic_mem_rdata, 128'h55);
    tick();
    tick();

    // Illegal D read+write: only the write goes out, rdata untouched.
    dc_mem_read  = 1'b1;
    dc_mem_write = 1'b1;
    dc_mem_addr  = 28'h80;
    dc_mem_wdata = 128'hCAFE;
    tick();
    chk("ill_write", {127'd0, mem_write}, 128'd1);
    chk("ill_read0", {127'd0, mem_read}, 128'd0);
    mem_ready = 1'b1;
    mem_rdata = 128'hDEAD;
    tick();
    mem_ready = 1'b0;
    dc_mem_read  = 1'b0;
    dc_mem_write = 1'b0;
    chk("ill_dc_ready", {127'd0, dc_mem_ready}, 128'd1);
    chk("ill_dc_rdata_kept", dc_mem_rdata, 128'h77);
    tick();
    tick();

    // Reset two cycles after mem_read rises: asynchronous abort.
    ic_mem_read = 1'b1;
    ic_mem_addr = 28'h90;
    tick();
    chk("rm_read", {127'd0, mem_read}, 128'd1);
    tick();
    tick();
    #2;
    proc_reset = 1'b1;
    #1;
    chk_all_zero("rm_async");
    ic_mem_read = 1'b0;
    tick();
    proc_reset = 1'b0;
    tick();
    chk("rm_no_ready", {127'd0, ic_mem_ready}, 128'd0);
    chk("rm_idle", {127'd0, mem_read}, 128'd0);
    ic_mem_read = 1'b1;
    ic_mem_addr = 28'hA0;
    tick();
    chk("rm_fresh_read", {127'd0, mem_read}, 128'd1);
    chk("rm_fresh_addr", {100'd0, mem_addr}, 128'hA0);
    mem_ready = 1'b1;
    mem_rdata = 128'h66;
    tick();
    mem_ready = 1'b0;
    ic_mem_read = 1'b0;
    chk("rm_fresh_ready", {127'd0, ic_mem_ready}, 128'd1);
    chk("rm_fresh_rdata", ic_mem_rdata, 128'h66);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-client arbiter that shares the single 128-bit line-wide memory port between the instruction cache and the data cache. It sits directly downstream of both caches and directly upstream of the slow main memory. It serialises their line requests and returns each read line with a one-cycle `ready` pulse. The returned line is held stable afterwards, because the caches sample it one cycle after `ready`.

## Interface
- `ADDR_W`, 28, line address width (word address with the 2 offset bits dropped)
- `DATA_W`, 128, line width
- `clk` in 1 — single clock, rising edge
- `proc_reset` in 1 — asynchronous, active-high reset
- `ic_mem_read` in 1 — I-cache line read request, level, held until its `ready`
- `ic_mem_addr` in ADDR_W — I-cache line address
- `ic_mem_rdata` out DATA_W — line returned to I-cache, held
- `ic_mem_ready` out 1 — one-cycle completion pulse to I-cache
- `dc_mem_read` / `dc_mem_write` in 1 — D-cache line read / write-back request, level
- `dc_mem_addr` in ADDR_W; `dc_mem_wdata` in DATA_W
- `dc_mem_rdata` out DATA_W; `dc_mem_ready` out 1 — as I-side
- `mem_read` / `mem_write` out 1; `mem_addr` out ADDR_W; `mem_wdata` out DATA_W — memory request, all registered
- `mem_rdata` in DATA_W; `mem_ready` in 1 — memory response

## Operation
- FSM states:
  - `IDLE`: no request on the memory port.
  - `GNT_I`: I-cache transaction is on the memory port.
  - `GNT_D`: D-cache transaction is on the memory port.
  - `RELEASE`: one dead cycle after every completion, so the finished client can drop its level request.
- `IDLE`, one client requesting:
  - Grant that client.
  - Register its addr, wdata and command onto the `mem_*` outputs.
- `IDLE`, both clients requesting: round-robin.
  - The client that did not win the last grant wins the tie.
  - After reset, D wins first.
- D-side request with both `dc_mem_read` and `dc_mem_write` high:
  - This is illegal.
  - Only `mem_write` is issued and the read is ignored.
- Addr, wdata and command are latched at grant. They stay constant on `mem_*` until completion, even if the client inputs change.
- `GNT_x`, `mem_ready` high (first cycle only):
  - Next cycle: `mem_read`/`mem_write` are deasserted.
  - Next cycle: the granted client's `*_mem_ready` pulses high for exactly 1 cycle.
  - For a read, the granted client's `*_mem_rdata` register loads `mem_rdata`.
  - The state moves to `RELEASE`, then to `IDLE`.
- `*_mem_rdata` holds until that client's next read completes. It is unaffected by the other client and by writes.
- `mem_ready` outside `GNT_x` is ignored. A `mem_ready` held high for several cycles counts once.
- Addresses and data pass through unmodified; there is no arithmetic.

## Timing
- Reset value of every output is 0: `mem_*` = 0, both `*_mem_ready` = 0, both `*_mem_rdata` = 0.
- Reset also puts the state in `IDLE` and sets the RR pointer so that D has priority.
- Cycle timeline for one transaction:
  - Request seen in `IDLE` at cycle t: `mem_read`/`mem_write` high from t+1.
  - `mem_ready` at cycle r: client `ready` and `rdata` valid at r+1, and `mem_*` command low at r+1.
  - `RELEASE` at r+1, `IDLE` at r+2.
  - The next grant is issued at r+2 at the earliest, with `mem_*` high at r+3.
- Overhead versus direct connection: 1 cycle request latency plus a 2-cycle turnaround.
- A client request arriving while the other client is granted waits. It is never dropped.
- Reset asserted mid-transaction:
  - Immediate abort; all outputs go to 0 asynchronously.
  - The memory transaction is abandoned, and no `ready` is issued for it.
- Request deasserted before completion is a protocol violation. The arbiter still completes the latched transaction and pulses `ready`.

## Structure
- State encodings go in the shared memory-subsystem include, alongside the default `ADDR_W`/`DATA_W` values used by the caches and memory model.
- One sub-module, `arb_rdata_hold`, instantiated twice: the per-client `rdata` capture register and `ready` pulse generator, driven by a load strobe.
- The FSM, RR pointer and `mem_*` output registers stay in the top module.

## Test plan
- I-only read:
  - Stimulus: `ic_mem_addr`=28'h0000010; memory responds `mem_ready` 4 cycles after `mem_read`, with `mem_rdata`=128'hA5…A5.
  - Required: `mem_read` rises 1 cycle after the request; `ic_mem_ready` pulses once; `ic_mem_rdata`=A5…A5 and held ≥3 cycles; `dc_mem_ready` never pulses.
- Simultaneous requests out of reset:
  - Stimulus: `ic` read at 0x10 and `dc` read at 0x20 in the same cycle.
  - Required: D served first (`mem_addr`=0x20), then I (0x10); the second `mem_read` is high exactly 3 cycles after the first `mem_ready`.
- Round-robin:
  - Stimulus: both clients request continuously for 4 transactions.
  - Required: grant order D, I, D, I.
- D write-back:
  - Stimulus: `dc_mem_write`, addr 0x30, wdata 128'h1234.
  - Required: `mem_write`=1, `mem_wdata`=0x1234 stable until `mem_ready`; `dc_mem_ready` pulses; `dc_mem_rdata` unchanged.
- `mem_ready` held high 3 cycles:
  - Required: exactly one client `ready` pulse and one transaction; a new grant follows only after `RELEASE`.
- Reset mid-transaction:
  - Stimulus: assert `proc_reset` 2 cycles after `mem_read` rises.
  - Required: all outputs 0 in the same cycle; no `ready` pulse; a fresh I request afterwards completes normally.
